// File: rtl/spi_slave.sv
// Mode-0 SPI slave: oversamples the SPI pins on i_clk, receives MSB-first words
// and returns the contents of a single-entry transmit holding register (full duplex).
module spi_slave #(
  parameter int                    p_WORD_LEN  = 8,
  parameter logic [p_WORD_LEN-1:0] p_IDLE_WORD = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sclk,
  input  logic                  i_mosi,
  input  logic                  i_ss_n,
  output logic                  o_miso,
  input  logic [p_WORD_LEN-1:0] i_data,
  input  logic                  i_dv,
  output logic                  o_tx_ready,
  output logic [p_WORD_LEN-1:0] o_data,
  output logic                  o_dv,
  output logic                  o_active
);

  localparam int                CNT_W    = $clog2(p_WORD_LEN);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(p_WORD_LEN - 1);

  logic                  sclk_p0, sclk_p1, sclk_p2;
  logic                  ss_n_p0, ss_n_p1;
  logic                  mosi_p0, mosi_p1;
  logic [CNT_W-1:0]      bit_cnt;
  logic [p_WORD_LEN-1:0] rx_shift;
  logic [p_WORD_LEN-1:0] tx_shift;
  logic [p_WORD_LEN-1:0] hold;
  logic                  hold_full;
  logic                  sclk_rise, sclk_fall, first_rise;
  logic [p_WORD_LEN-1:0] sel_word;

  // Stage p2: edge detect on synced sclk; mosi_p1 lines up with the detected edge
  assign sclk_rise  = sclk_p1 & ~sclk_p2 & ~ss_n_p1;
  assign sclk_fall  = ~sclk_p1 & sclk_p2 & ~ss_n_p1;
  assign first_rise = sclk_rise & ~o_active;

  assign sel_word   = hold_full ? hold : p_IDLE_WORD;
  // Before the first edge the next word's MSB is presented straight from the selection
  assign o_miso     = o_active ? tx_shift[p_WORD_LEN-1] : sel_word[p_WORD_LEN-1];
  assign o_tx_ready = ~hold_full;

  // Stage p0/p1: two-flop synchronisers, plus framing and hold-register control
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_p0   <= 1'b0;
      sclk_p1   <= 1'b0;
      sclk_p2   <= 1'b0;
      ss_n_p0   <= 1'b1;
      ss_n_p1   <= 1'b1;
      mosi_p0   <= 1'b0;
      mosi_p1   <= 1'b0;
      bit_cnt   <= '0;
      o_active  <= 1'b0;
      o_dv      <= 1'b0;
      o_data    <= '0;
      hold_full <= 1'b0;
    end else begin
      sclk_p0 <= i_sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      ss_n_p0 <= i_ss_n;
      ss_n_p1 <= ss_n_p0;
      mosi_p0 <= i_mosi;
      mosi_p1 <= mosi_p0;
      o_dv    <= 1'b0;

      if (ss_n_p1) begin
        bit_cnt  <= '0;
        o_active <= 1'b0;
      end else if (sclk_rise) begin
        if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          o_active <= 1'b0;
          o_data   <= {rx_shift[p_WORD_LEN-2:0], mosi_p1};
          o_dv     <= 1'b1;
        end else begin
          bit_cnt  <= bit_cnt + CNT_W'(1);
          o_active <= 1'b1;
        end
      end

      // A full hold blocks i_dv, so consume and accept never coincide on a full hold
      if (i_dv && !hold_full)
        hold_full <= 1'b1;
      else if (first_rise)
        hold_full <= 1'b0;
    end
  end

  // Stage p2 datapath: shift registers and hold contents carry no reset
  always_ff @(posedge i_clk) begin
    if (sclk_rise)
      rx_shift <= {rx_shift[p_WORD_LEN-2:0], mosi_p1};

    if (first_rise)
      tx_shift <= sel_word;
    else if (sclk_fall && o_active)
      tx_shift <= {tx_shift[p_WORD_LEN-2:0], 1'b0};

    if (i_dv && !hold_full)
      hold <= i_data;
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural mode-0 master drives the pins; received words
// are checked by a scoreboard monitor, master-side words against hand values.
module tb_spi_slave;

  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, mosi, ss_n, miso;
  logic [7:0] i_data;
  logic       i_dv;
  logic       o_tx_ready;
  logic [7:0] o_data;
  logic       o_dv;
  logic       o_active;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  spi_slave #(.p_WORD_LEN(8), .p_IDLE_WORD(8'h00)) dut (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_mosi(mosi), .i_ss_n(ss_n),
    .o_miso(miso), .i_data(i_data), .i_dv(i_dv), .o_tx_ready(o_tx_ready),
    .o_data(o_data), .o_dv(o_dv), .o_active(o_active)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every o_dv pulse must match the oldest expected word
  always @(negedge clk) begin
    if (o_dv) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_word unexpected o_dv actual=%h required=none", o_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (o_data !== e) begin
          errors++;
          $display("FAIL rx_word actual=%h required=%h", o_data, e);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic write_hold(input logic [7:0] d);
    i_data = d;
    i_dv   = 1'b1;
    cyc(1);
    i_dv   = 1'b0;
  endtask

  // Mode-0 master: mosi set half a period before each rise, miso sampled at the rise.
  // refill_at pulses i_dv that many cycles after the first pin rise (0 = never).
  task automatic xfer(input logic [7:0] tx, input int nbits, input int refill_at,
                      input logic [7:0] refill_data, output logic [7:0] rx,
                      output logic rdy4);
    rx     = '0;
    rdy4   = 1'b0;
    i_data = refill_data;
    for (int b = 0; b < nbits; b++) begin
      mosi = tx[7-b];
      cyc(HALF);
      sclk = 1'b1;
      rx[7-b] = miso;
      for (int k = 0; k < HALF; k++) begin
        if (b == 0 && k == 4) rdy4 = o_tx_ready;
        i_dv = (b == 0 && refill_at != 0 && k == refill_at);
        cyc(1);
      end
      i_dv = 1'b0;
      sclk = 1'b0;
    end
  endtask

  logic [7:0] rx;
  logic       rdy4;

  initial begin
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b0; i_data = '0; i_dv = 1'b0;
    cyc(3);
    chk("reset o_data", o_data, 8'h00);
    chk("reset o_dv", o_dv, 1'b0);
    chk("reset o_active", o_active, 1'b0);
    chk("reset o_tx_ready", o_tx_ready, 1'b1);
    chk("reset o_miso", miso, 1'b0);
    rst = 1'b0;
    cyc(4);

    // 1: idle hold, single word
    exp_q.push_back(8'hEE);
    xfer(8'hEE, 8, 0, 8'h00, rx, rdy4);
    chk("t1 master rx", rx, 8'h00);
    chk("t1 tx_ready", o_tx_ready, 1'b1);

    // 2: hold loaded while idle
    write_hold(8'hA5);
    chk("t2 tx_ready low", o_tx_ready, 1'b0);
    exp_q.push_back(8'h5A);
    xfer(8'h5A, 8, 0, 8'h00, rx, rdy4);
    chk("t2 master rx", rx, 8'hA5);
    chk("t2 ready within 4", rdy4, 1'b1);

    // 3: back-to-back words, hold refilled on ready
    write_hold(8'h0F);
    exp_q.push_back(8'h3C);
    xfer(8'h3C, 8, 4, 8'hF0, rx, rdy4);
    chk("t3 master rx0", rx, 8'h0F);
    exp_q.push_back(8'hC3);
    xfer(8'hC3, 8, 0, 8'h00, rx, rdy4);
    chk("t3 master rx1", rx, 8'hF0);

    // 4: aborted partial word, then a full frame
    xfer(8'hFF, 5, 0, 8'h00, rx, rdy4);
    chk("t4 active mid-word", o_active, 1'b1);
    ss_n = 1'b1;
    cyc(6);
    chk("t4 active after ss", o_active, 1'b0);
    chk("t4 o_data kept", o_data, 8'hC3);
    ss_n = 1'b0;
    cyc(6);
    exp_q.push_back(8'h81);
    xfer(8'h81, 8, 0, 8'h00, rx, rdy4);
    chk("t4 master rx", rx, 8'h00);

    // 5: second write to a full hold is dropped
    write_hold(8'h11);
    chk("t5 tx_ready low", o_tx_ready, 1'b0);
    write_hold(8'h22);
    exp_q.push_back(8'h00);
    xfer(8'h00, 8, 0, 8'h00, rx, rdy4);
    chk("t5 master rx", rx, 8'h11);
    chk("t5 tx_ready", o_tx_ready, 1'b1);
    exp_q.push_back(8'h42);
    xfer(8'h42, 8, 0, 8'h00, rx, rdy4);
    chk("t5 0x22 dropped", rx, 8'h00);

    // 6: write coincident with the first detected rise
    exp_q.push_back(8'h12);
    xfer(8'h12, 8, 2, 8'h77, rx, rdy4);
    chk("t6 master rx0", rx, 8'h00);
    exp_q.push_back(8'h34);
    xfer(8'h34, 8, 0, 8'h00, rx, rdy4);
    chk("t6 master rx1", rx, 8'h77);

    // 6b: reset mid-word with the hold full
    xfer(8'hF0, 4, 4, 8'h55, rx, rdy4);
    chk("t6b pre active", o_active, 1'b1);
    chk("t6b pre tx_ready", o_tx_ready, 1'b0);
    rst = 1'b1;
    cyc(1);
    chk("t6b rst o_data", o_data, 8'h00);
    chk("t6b rst o_dv", o_dv, 1'b0);
    chk("t6b rst o_active", o_active, 1'b0);
    chk("t6b rst tx_ready", o_tx_ready, 1'b1);
    chk("t6b rst o_miso", miso, 1'b0);
    rst = 1'b0;
    cyc(5);
    exp_q.push_back(8'h96);
    xfer(8'h96, 8, 0, 8'h00, rx, rdy4);
    chk("t6b post master rx", rx, 8'h00);

    cyc(8);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
